// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input and ALU command/error output bundle for uart_cmd_decoder.
// The decoder uses the master modport and its environment uses the slave modport.
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       err_opcode;
    logic       err_timeout;
    logic       err_overrun;
    logic       err_chk;

    modport master (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, alu_op, alu_a, alu_b,
        output err_opcode, err_timeout, err_overrun, err_chk
    );

    modport slave (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, alu_op, alu_a, alu_b,
        input  err_opcode, err_timeout, err_overrun, err_chk
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Assembles HEADER/opcode/A/B[/checksum] byte frames into held ALU commands with error pulses.
// Define UART_CMD_CHECKSUM_EN to require a trailing checksum byte (HEADER^op^A^B).
module uart_cmd_decoder #(
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter logic [3:0]  MAX_OP       = 4'd9,
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input logic               clk,
    input logic               rst,
    uart_cmd_decoder_if.master bus
);
    localparam int unsigned CntW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {StIdle, StOpcode, StOpA, StOpB, StChk, StHold} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      op_q;
    logic [7:0]      a_q;
    logic            cmd_valid_q;
    logic [3:0]      alu_op_q;
    logic [7:0]      alu_a_q;
    logic [7:0]      alu_b_q;
    logic            err_opcode_q;
    logic            err_timeout_q;
    logic            err_overrun_q;

    logic in_frame;
    logic bad_op;

    assign in_frame = (state_q == StOpcode) || (state_q == StOpA) ||
                      (state_q == StOpB) || (state_q == StChk);
    assign bad_op   = (bus.rx_data[7:4] != 4'h0) || (bus.rx_data[3:0] > MAX_OP);

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] b_q;
    logic       err_chk_q;
    logic [7:0] chk_exp;

    assign chk_exp = HEADER ^ {4'h0, op_q} ^ a_q ^ b_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            op_q          <= '0;
            a_q           <= '0;
            cmd_valid_q   <= 1'b0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            b_q           <= '0;
            err_chk_q     <= 1'b0;
`endif
        end else begin
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            err_chk_q     <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (bus.rx_valid && (bus.rx_data == HEADER)) state_q <= StOpcode;
                end
                StOpcode: begin
                    if (bus.rx_valid) begin
                        if (bad_op) begin
                            err_opcode_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            op_q    <= bus.rx_data[3:0];
                            state_q <= StOpA;
                        end
                    end
                end
                StOpA: begin
                    if (bus.rx_valid) begin
                        a_q     <= bus.rx_data;
                        state_q <= StOpB;
                    end
                end
                StOpB: begin
                    if (bus.rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
                        b_q     <= bus.rx_data;
                        state_q <= StChk;
`else
                        alu_op_q    <= op_q;
                        alu_a_q     <= a_q;
                        alu_b_q     <= bus.rx_data;
                        cmd_valid_q <= 1'b1;
                        state_q     <= StHold;
`endif
                    end
                end
                StChk: begin
`ifdef UART_CMD_CHECKSUM_EN
                    if (bus.rx_valid) begin
                        if (bus.rx_data == chk_exp) begin
                            alu_op_q    <= op_q;
                            alu_a_q     <= a_q;
                            alu_b_q     <= b_q;
                            cmd_valid_q <= 1'b1;
                            state_q     <= StHold;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StHold: begin
                    // Bytes arriving while a command is held are lost, even on the accept cycle.
                    if (bus.rx_valid) err_overrun_q <= 1'b1;
                    if (cmd_valid_q && bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Inter-byte watchdog; a strobe always wins over an expiring count.
            if (in_frame) begin
                if (bus.rx_valid) begin
                    cnt_q <= '0;
                end else if (cnt_q == CntLast) begin
                    err_timeout_q <= 1'b1;
                    state_q       <= StIdle;
                    cnt_q         <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.err_opcode  = err_opcode_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_overrun = err_overrun_q;
`ifdef UART_CMD_CHECKSUM_EN
    assign bus.err_chk     = err_chk_q;
`else
    assign bus.err_chk     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed scenarios plus random byte traffic against a
// frame-level reference model; honours UART_CMD_CHECKSUM_EN when defined.
module tb_uart_cmd_decoder;
    localparam int unsigned TO = 100;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int unsigned FLEN = 5;
`else
    localparam int unsigned FLEN = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(
        .HEADER      (8'hA5),
        .MAX_OP      (4'd9),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes of the frame in progress, plus the held command.
    logic [7:0] frame[$];
    logic       m_hold;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    int         m_idle;
    logic       e_opc, e_to, e_ovr, e_chk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        frame.delete();
        m_hold = 1'b0;
        m_op   = '0;
        m_a    = '0;
        m_b    = '0;
        m_idle = 0;
        {e_opc, e_to, e_ovr, e_chk} = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic rdy);
        {e_opc, e_to, e_ovr, e_chk} = '0;
        if (m_hold) begin
            if (v) e_ovr = 1'b1;
            if (rdy) m_hold = 1'b0;
        end else if (frame.size() != 0) begin
            if (v) begin
                m_idle = 0;
                frame.push_back(d);
                if (frame.size() == 2 && d > 8'h09) begin
                    e_opc = 1'b1;
                    frame.delete();
                end else if (frame.size() == FLEN) begin
                    if (FLEN == 5 && d != (frame[0] ^ frame[1] ^ frame[2] ^ frame[3])) begin
                        e_chk = 1'b1;
                    end else begin
                        m_hold = 1'b1;
                        m_op   = frame[1][3:0];
                        m_a    = frame[2];
                        m_b    = frame[3];
                    end
                    frame.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    e_to = 1'b1;
                    frame.delete();
                    m_idle = 0;
                end
            end
        end else if (v && d == 8'hA5) begin
            frame.push_back(d);
            m_idle = 0;
        end
    endtask

    task automatic compare_all();
        check("cmd_valid", 8'(bus.cmd_valid), 8'(m_hold));
        check("alu_op", 8'(bus.alu_op), 8'(m_op));
        check("alu_a", bus.alu_a, m_a);
        check("alu_b", bus.alu_b, m_b);
        check("err_opcode", 8'(bus.err_opcode), 8'(e_opc));
        check("err_timeout", 8'(bus.err_timeout), 8'(e_to));
        check("err_overrun", 8'(bus.err_overrun), 8'(e_ovr));
        check("err_chk", 8'(bus.err_chk), 8'(e_chk));
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic rdy);
        bus.rx_valid  = v;
        bus.rx_data   = d;
        bus.cmd_ready = rdy;
        @(posedge clk);
        model_step(v, d, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                              input int max_gap);
        logic [7:0] bytes[5];
        bytes[0] = 8'hA5;
        bytes[1] = op;
        bytes[2] = a;
        bytes[3] = b;
        bytes[4] = 8'hA5 ^ op ^ a ^ b;
        for (int i = 0; i < FLEN; i++) begin
            cycle(1'b1, bytes[i], 1'b0);
            if (i != FLEN - 1) begin
                for (int g = $urandom_range(max_gap, 0); g > 0; g--) cycle(1'b0, 8'($urandom), 1'b0);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.cmd_ready = 1'b0;
        model_reset();
        do_reset();
        check("reset_cmd_valid", 8'(bus.cmd_valid), 8'h00);

        // Basic frame, held until accepted.
        send_frame(8'h02, 8'h0C, 8'h03, 0);
        check("t1_valid", 8'(bus.cmd_valid), 8'h01);
        check("t1_op", 8'(bus.alu_op), 8'h02);
        check("t1_a", bus.alu_a, 8'h0C);
        check("t1_b", bus.alu_b, 8'h03);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        check("t1_still_held", 8'(bus.cmd_valid), 8'h01);
        cycle(1'b0, 8'h00, 1'b1);
        check("t1_accepted", 8'(bus.cmd_valid), 8'h00);

        // Junk before header, then illegal opcode.
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h0F, 1'b0);
        check("t2_err_opcode", 8'(bus.err_opcode), 8'h01);
        cycle(1'b0, 8'h00, 1'b0);
        check("t2_pulse_once", 8'(bus.err_opcode), 8'h00);
        check("t2_no_cmd", 8'(bus.cmd_valid), 8'h00);

        // Timeout on exactly the TO-th strobe-free cycle.
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        repeat (TO - 1) cycle(1'b0, 8'h00, 1'b0);
        check("t3_no_early_timeout", 8'(bus.err_timeout), 8'h00);
        cycle(1'b0, 8'h00, 1'b0);
        check("t3_timeout", 8'(bus.err_timeout), 8'h01);
        send_frame(8'h01, 8'h05, 8'h03, 0);
        check("t3_recovered", 8'(bus.cmd_valid), 8'h01);
        cycle(1'b0, 8'h00, 1'b1);

        // Overrun while holding, including on the accept cycle.
        send_frame(8'h07, 8'h11, 8'h22, 2);
        cycle(1'b1, 8'h55, 1'b0);
        check("t4_overrun", 8'(bus.err_overrun), 8'h01);
        check("t4_a_kept", bus.alu_a, 8'h11);
        cycle(1'b1, 8'h77, 1'b1);
        check("t4_overrun_accept", 8'(bus.err_overrun), 8'h01);
        check("t4_accepted", 8'(bus.cmd_valid), 8'h00);

`ifdef UART_CMD_CHECKSUM_EN
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        check("t5_chk_ok", 8'(bus.cmd_valid), 8'h01);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h00, 1'b0);
        check("t5_chk_err", 8'(bus.err_chk), 8'h01);
        check("t5_no_cmd", 8'(bus.cmd_valid), 8'h00);
`endif

        // Reset mid-frame abandons it silently.
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        do_reset();
        cycle(1'b1, 8'h03, 1'b0);
        check("t6_no_cmd", 8'(bus.cmd_valid), 8'h00);
        check("t6_alu_a_zero", bus.alu_a, 8'h00);
        repeat (FLEN) cycle(1'b0, 8'h00, 1'b0);

        // Random traffic: well-formed frames, stray bytes, long gaps and random ready.
        for (int it = 0; it < 400; it++) begin
            int kind;
            kind = int'($urandom_range(9, 0));
            if (kind < 4) begin
                send_frame(8'($urandom_range(11, 0)), 8'($urandom), 8'($urandom), 3);
            end else if (kind < 8) begin
                for (int k = $urandom_range(8, 1); k > 0; k--) begin
                    logic [7:0] d;
                    int sel;
                    sel = int'($urandom_range(9, 0));
                    if (sel < 3) d = 8'hA5;
                    else if (sel < 6) d = 8'($urandom_range(12, 0));
                    else d = 8'($urandom);
                    cycle(1'($urandom_range(1, 0)), d, ($urandom_range(3, 0) == 0));
                end
            end else if (kind == 8) begin
                for (int k = $urandom_range(TO + 5, TO - 5); k > 0; k--)
                    cycle(1'b0, 8'($urandom), 1'b0);
            end else begin
                for (int k = $urandom_range(4, 1); k > 0; k--)
                    cycle(1'b0, 8'($urandom), 1'($urandom_range(1, 0)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
